// File: rtl/wb_status_sequencer_pkg.sv
// Shared definitions for the Wishbone status sequencer: register map, bit
// positions, entry layout and the pin positions the wrapper uses.
package wb_status_sequencer_pkg;

    localparam int ENTRY_W = 8;

    // Word offsets, i.e. byte address bits [3:2]
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_EMPTY = 4;
    localparam int ST_FULL  = 5;
    localparam int ST_OVF   = 6;
    localparam int ST_HOLD  = 7;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

    localparam int CODE_PIN_LSB = 20;
    localparam int FLAG_PIN_LSB = 36;

    typedef struct packed {
        logic [1:0] flag;
        logic [5:0] code;
    } entry_t;

endpackage

// File: rtl/wb_status_sequencer_fifo.sv
// Synchronous FIFO of status entries with flush; pointers wrap modulo DEPTH.
module status_fifo
    import wb_status_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot a full-queue push needs
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; only pointers and
    // count carry state that matters, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state is only ever assigned with <= so every reader
    // sees the pre-edge value, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_status_sequencer.sv
// Wishbone slave that queues firmware status entries and plays them onto the
// status pins, holding each one for at least HOLD_CYCLES clocks.
module wb_status_sequencer
    import wb_status_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          DEPTH       = 8,
    parameter int          HOLD_CYCLES = 64,
    parameter logic [5:0]  RESET_CODE  = 6'h3F
) (
    input  logic        wb_clk_i,
    input  logic        rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [5:0]  code_o,
    output logic [1:0]  flag_o,
    output logic [7:0]  status_oeb_o
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_HOLD = 1'b1;
    localparam int   CW     = $clog2(DEPTH) + 1;
    localparam int   HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic          ack_q;
    logic [31:0]   dat_q;
    logic          ovf_q;
    logic          state;
    logic [HW-1:0] hold_cnt;
    entry_t        pins_q;

    logic          req, accept, wr;
    logic [1:0]    off;
    logic          push, flush, clr_ovf, pop;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [7:0]    status;
    logic [7:0]    rd_data;
    logic          unused_bits;

    // The ack cycle itself blocks acceptance, giving one access per two clocks
    assign req     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign accept  = req && !ack_q;
    assign off     = wbs_adr_i[3:2];
    assign wr      = accept && wbs_we_i && wbs_sel_i[0];
    assign push    = wr && (off == OFF_DATA);
    assign flush   = wr && (off == OFF_CTRL) && wbs_dat_i[CTRL_FLUSH];
    assign clr_ovf = wr && (off == OFF_CTRL) && wbs_dat_i[CTRL_CLR_OVF];
    assign pop     = !fifo_empty && ((state == S_IDLE) || (hold_cnt == '0));

    assign unused_bits = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    status_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wbs_dat_i[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status          = '0;
        status[3:0]     = 4'(fifo_count);
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVF]   = ovf_q;
        status[ST_HOLD]  = (hold_cnt != '0);
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case can infer a latch.
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_DATA:   rd_data = pins_q;
            OFF_STATUS: rd_data = status;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ack_q <= accept;
            dat_q <= (accept && !wbs_we_i) ? {24'b0, rd_data} : '0;
            if (clr_ovf)
                ovf_q <= 1'b0;
            else if (push && fifo_full && !pop)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            pins_q   <= {2'b00, RESET_CODE};
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        pins_q   <= fifo_dout;
                        hold_cnt <= HOLD_LOAD;
                        state    <= S_HOLD;
                    end
                end
                default: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (pop) begin
                        pins_q   <= fifo_dout;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign code_o       = pins_q.code;
    assign flag_o       = pins_q.flag;
    assign status_oeb_o = '0;

endmodule

// File: tb/tb_wb_status_sequencer.sv
// Self-checking bench: a scoreboard of expected pin values filled at each DATA
// write and drained by a monitor whenever the pins change.
module tb_wb_status_sequencer;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [3:0]  A_DATA   = 4'h0;
    localparam logic [3:0]  A_STATUS = 4'h4;
    localparam logic [3:0]  A_CTRL   = 4'h8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, tgt = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;

    logic        ack0, ack1, ack;
    logic [31:0] dat0, dat1, rdat_bus;
    logic [5:0]  code0, code1;
    logic [1:0]  flag0, flag1;
    logic [7:0]  oeb0, oeb1;

    always #5 clk = ~clk;

    assign ack      = tgt ? ack1 : ack0;
    assign rdat_bus = tgt ? dat1 : dat0;

    wb_status_sequencer #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
        .wb_clk_i(clk), .rst_ni(rst_n),
        .wbs_cyc_i(cyc && !tgt), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack0), .wbs_dat_o(dat0),
        .code_o(code0), .flag_o(flag0), .status_oeb_o(oeb0)
    );

    wb_status_sequencer #(.DEPTH(4), .HOLD_CYCLES(64)) dut64 (
        .wb_clk_i(clk), .rst_ni(rst_n),
        .wbs_cyc_i(cyc && tgt), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack1), .wbs_dat_o(dat1),
        .code_o(code1), .flag_o(flag1), .status_oeb_o(oeb1)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    bit         mon_en = 1'b0;
    logic [7:0] prev_pins = 8'h3F;
    int         cyc_cnt = 0, last_change = 0, last_hold = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor on the HOLD_CYCLES=4 instance
    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        if (mon_en && ({flag0, code0} != prev_pins)) begin
            last_hold   = cyc_cnt - last_change;
            last_change = cyc_cnt;
            if (sb.size() == 0)
                check("sb_unexpected_change", {flag0, code0}, prev_pins);
            else
                check("sb_pins", {flag0, code0}, sb.pop_front());
        end
        prev_pins = {flag0, code0};
    end

    task automatic wb_access(input logic t, input logic w, input logic [3:0] a,
                             input logic [7:0] d, input logic [3:0] s,
                             output logic [31:0] r);
        bit got = 1'b0;
        r    = '0;
        tgt  = t;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        sel  = s;
        adr  = BASE | {28'b0, a};
        wdat = {24'hA5A5A5, d};
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                r   = rdat_bus;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        sel = 4'hF;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr_data(input logic t, input logic [7:0] d);
        logic [31:0] r;
        if (!t) sb.push_back(d);
        wb_access(t, 1'b1, A_DATA, d, 4'hF, r);
    endtask

    task automatic wait_pins(input string tag, input logic [7:0] exp, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #2;
            if ({flag0, code0} == exp) seen = 1'b1;
        end
        check(tag, {flag0, code0}, exp);
    endtask

    initial begin
        logic [31:0] r;
        int acks;

        // 1: reset values
        #27 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_code", code0, 6'h3F);
        check("rst_flag", flag0, 2'b00);
        check("rst_oeb", oeb0, 8'h00);
        wb_access(1'b0, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("rst_status", r, 32'h10);
        wb_access(1'b1, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("rst_status64", r, 32'h10);

        // 2: back-to-back entries, each held exactly HOLD_CYCLES
        wr_data(1'b0, 8'h00);
        wr_data(1'b0, 8'h01);
        wait_pins("t2_pins", 8'h01, 20);
        check("t2_hold", last_hold, 4);
        wb_access(1'b0, 1'b0, A_DATA, 8'h00, 4'hF, r);
        check("t2_readback", r, 32'h01);

        // 3: flag field carried with the code
        repeat (8) @(posedge clk);
        #1;
        wr_data(1'b0, 8'h41);
        wr_data(1'b0, 8'h43);
        wait_pins("t3_pins", 8'h43, 20);
        check("t3_hold", last_hold, 4);
        check("t3_flag", flag0, 2'b01);

        // Write with sel[0]=0 is acked but does nothing
        repeat (8) @(posedge clk);
        #1;
        wb_access(1'b0, 1'b1, A_DATA, 8'h22, 4'hE, r);
        repeat (4) @(posedge clk);
        #1;
        check("sel0_pins", {flag0, code0}, 8'h43);
        wb_access(1'b0, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("sel0_status", r, 32'h10);

        // 4: overflow on the HOLD_CYCLES=64 instance
        for (int i = 0; i < 6; i++) wr_data(1'b1, 8'h10 + 8'(i));
        wb_access(1'b1, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("t4_status_ovf", r, 32'hE4);
        check("t4_pins64", {flag1, code1}, 8'h10);
        wb_access(1'b1, 1'b1, A_CTRL, 8'h02, 4'hF, r);
        wb_access(1'b1, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("t4_status_clr", r, 32'hA4);

        // 5: flush mid-hold; current entry finishes and the pins stay put
        wr_data(1'b0, 8'h0A);
        wr_data(1'b0, 8'h0B);
        wr_data(1'b0, 8'h0C);
        wb_access(1'b0, 1'b1, A_CTRL, 8'h01, 4'hF, r);
        if (sb.size() > 0) void'(sb.pop_back());
        wb_access(1'b0, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("t5_status_cnt", r[5:0], 6'h10);
        repeat (12) @(posedge clk);
        #1;
        check("t5_pins", {flag0, code0}, 8'h0B);
        wb_access(1'b0, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("t5_status_idle", r, 32'h10);

        // 6: asynchronous reset mid-hold with entries queued
        wr_data(1'b0, 8'h05);
        wr_data(1'b0, 8'h06);
        wr_data(1'b0, 8'h07);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_code", code0, 6'h3F);
        check("t6_flag", flag0, 2'b00);
        check("t6_oeb", oeb0, 8'h00);
        check("t6_ack", ack0, 1'b0);
        check("t6_dat", dat0, 32'h0);
        check("t6_code64", code1, 6'h3F);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        wb_access(1'b0, 1'b0, A_STATUS, 8'h00, 4'hF, r);
        check("t6_status", r, 32'h10);
        repeat (6) @(posedge clk);
        #1;
        check("t6_pins_idle", {flag0, code0}, 8'h3F);

        // Access outside the window is never acked
        acks = 0;
        tgt = 1'b0;
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b1;
        adr = BASE + 32'h10;
        wdat = 32'h0000_0015;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ack0) acks++;
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        check("oow_ack", acks, 0);
        repeat (6) @(posedge clk);
        #1;
        check("oow_pins", {flag0, code0}, 8'h3F);
        check("sb_left", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
